// File: rtl/b03_requester.sv
// b03_requester: four independent resource-requesting channels.
//
// Each channel accepts a job (length sampled from the shared job_len), raises
// its request line until the arbiter grants it, holds the resource for the
// captured number of cycles, then drops the request and waits for the
// grant to be withdrawn before reporting completion.
//
// Optional feature: define B03_REQ_TIMEOUT_EN to abandon requests that wait
// TIMEOUT_CYCLES cycles without a grant.
//
// Ports:
//   clock                 single clock, rising edge
//   reset                 synchronous active-high reset
//   job_valid[3:0]        per-channel job offer (bit i -> channel i+1)
//   job_len[3:0]          hold length in cycles (0 treated as 1)
//   grant[3:0]            one-hot grant from the arbiter
//   request1..request4    per-channel request lines
//   job_ready[3:0]        channel is idle
//   done[3:0]             one-cycle pulse on job completion
//   timeout[3:0]          one-cycle pulse on an abandoned request
//   proto_err             one-cycle pulse on a grant protocol violation
module b03_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] job_valid,
    input  logic [3:0] job_len,
    input  logic [3:0] grant,
    output logic       request1,
    output logic       request2,
    output logic       request3,
    output logic       request4,
    output logic [3:0] job_ready,
    output logic [3:0] done,
    output logic [3:0] timeout,
    output logic       proto_err
);

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned LEN_W  = 4;

    // Elaboration-time range check on the timeout parameter
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("b03_requester: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [LEN_W-1:0]  len_q   [NUM_CH];
    logic [LEN_W-1:0]  len_d   [NUM_CH];
    logic [LEN_W-1:0]  hold_q  [NUM_CH];
    logic [LEN_W-1:0]  hold_d  [NUM_CH];

    logic [NUM_CH-1:0] request_q;
    logic [NUM_CH-1:0] request_d;
    logic [NUM_CH-1:0] ready_q;
    logic [NUM_CH-1:0] ready_d;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] done_d;
    logic              proto_q;
    logic              proto_d;

`ifdef B03_REQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = 8;

    logic [WAIT_W-1:0] wait_q  [NUM_CH];
    logic [WAIT_W-1:0] wait_d  [NUM_CH];
    logic [NUM_CH-1:0] timeout_q;
    logic [NUM_CH-1:0] timeout_d;
`endif

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                len_q[i]   <= '0;
                hold_q[i]  <= '0;
`ifdef B03_REQ_TIMEOUT_EN
                wait_q[i]  <= '0;
`endif
            end
            request_q <= '0;
            ready_q   <= '1;
            done_q    <= '0;
            proto_q   <= 1'b0;
`ifdef B03_REQ_TIMEOUT_EN
            timeout_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
                hold_q[i]  <= hold_d[i];
`ifdef B03_REQ_TIMEOUT_EN
                wait_q[i]  <= wait_d[i];
`endif
            end
            request_q <= request_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            proto_q   <= proto_d;
`ifdef B03_REQ_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    // Per-channel next state and next outputs
    always_comb begin
        // More than one grant bit set is always a violation
        proto_d = ((grant & (grant - 4'd1)) != 4'd0);
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]   = state_q[i];
            len_d[i]     = len_q[i];
            hold_d[i]    = hold_q[i];
            done_d[i]    = 1'b0;
`ifdef B03_REQ_TIMEOUT_EN
            wait_d[i]    = wait_q[i];
            timeout_d[i] = 1'b0;
`endif
            case (state_q[i])
                ST_IDLE: begin
                    if (grant[i]) begin
                        proto_d = 1'b1;
                    end
                    if (job_valid[i]) begin
                        state_d[i] = ST_WAIT;
                        len_d[i]   = (job_len == 4'd0) ? LEN_W'(1) : job_len;
`ifdef B03_REQ_TIMEOUT_EN
                        wait_d[i]  = '0;
`endif
                    end
                end
                ST_WAIT: begin
                    // A grant wins over an expiring wait counter
                    if (grant[i]) begin
                        state_d[i] = ST_HOLD;
                        hold_d[i]  = len_q[i];
                    end
`ifdef B03_REQ_TIMEOUT_EN
                    // Counter would reach TIMEOUT_CYCLES on this cycle
                    else if (wait_q[i] == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d[i]   = ST_IDLE;
                        timeout_d[i] = 1'b1;
                    end else begin
                        wait_d[i] = wait_q[i] + WAIT_W'(1);
                    end
`endif
                end
                ST_HOLD: begin
                    if (!grant[i]) begin
                        // Grant withdrawn early: abandon without done
                        proto_d    = 1'b1;
                        state_d[i] = ST_IDLE;
                    end else if (hold_q[i] == LEN_W'(1)) begin
                        state_d[i] = ST_REL;
                    end else begin
                        hold_d[i] = hold_q[i] - LEN_W'(1);
                    end
                end
                ST_REL: begin
                    if (!grant[i]) begin
                        done_d[i]  = 1'b1;
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
            request_d[i] = (state_d[i] == ST_WAIT) || (state_d[i] == ST_HOLD);
            ready_d[i]   = (state_d[i] == ST_IDLE);
        end
    end

    assign request1  = request_q[0];
    assign request2  = request_q[1];
    assign request3  = request_q[2];
    assign request4  = request_q[3];
    assign job_ready = ready_q;
    assign done      = done_q;
    assign proto_err = proto_q;

`ifdef B03_REQ_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = '0;
`endif

endmodule

// File: tb/tb_b03_requester.sv
// Testbench for b03_requester (default build, timeout feature disabled).
module tb_b03_requester;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_HOLD = 2;
    localparam int P_REL  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] job_valid;
    logic [3:0] job_len;
    logic [3:0] grant;
    logic       request1;
    logic       request2;
    logic       request3;
    logic       request4;
    logic [3:0] job_ready;
    logic [3:0] done;
    logic [3:0] timeout;
    logic       proto_err;

    wire  [3:0] req_vec = {request4, request3, request2, request1};

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel phase, job length, hold cycles still owed
    int         m_phase [4];
    int         m_len   [4];
    int         m_left  [4];
    logic [3:0] m_done;
    logic       m_proto;

    b03_requester #(.TIMEOUT_CYCLES(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .job_valid (job_valid),
        .job_len   (job_len),
        .grant     (grant),
        .request1  (request1),
        .request2  (request2),
        .request3  (request3),
        .request4  (request4),
        .job_ready (job_ready),
        .done      (done),
        .timeout   (timeout),
        .proto_err (proto_err)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (m_phase[i] == P_WAIT || m_phase[i] == P_HOLD) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (m_phase[i] == P_IDLE) r[i] = 1'b1;
        return r;
    endfunction

    // Advance the model by one clock edge with the given inputs
    task automatic model_step(input logic rst, input logic [3:0] jv,
                              input logic [3:0] jl, input logic [3:0] g);
        m_done  = 4'b0000;
        m_proto = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_phase[i] = P_IDLE;
                m_len[i]   = 0;
                m_left[i]  = 0;
            end
            return;
        end
        if ($countones(g) > 1) m_proto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (m_phase[i])
                P_IDLE: begin
                    if (g[i]) m_proto = 1'b1;
                    if (jv[i]) begin
                        m_phase[i] = P_WAIT;
                        m_len[i]   = (jl == 4'd0) ? 1 : int'(jl);
                    end
                end
                P_WAIT: begin
                    if (g[i]) begin
                        m_phase[i] = P_HOLD;
                        m_left[i]  = m_len[i];
                    end
                end
                P_HOLD: begin
                    if (!g[i]) begin
                        m_proto    = 1'b1;
                        m_phase[i] = P_IDLE;
                    end else begin
                        m_left[i] = m_left[i] - 1;
                        if (m_left[i] == 0) m_phase[i] = P_REL;
                    end
                end
                default: begin
                    if (!g[i]) begin
                        m_done[i]  = 1'b1;
                        m_phase[i] = P_IDLE;
                    end
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs, step the model, sample 1 time unit after the edge
    task automatic tick(input logic rst, input logic [3:0] jv,
                        input logic [3:0] jl, input logic [3:0] g);
        reset     = rst;
        job_valid = jv;
        job_len   = jl;
        grant     = g;
        model_step(rst, jv, jl, g);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 4'h0, 4'h0, 4'h0);
        tick(1'b1, 4'h0, 4'h0, 4'h0);
        checks++; if (req_vec !== 4'b0000) begin errors++; $display("FAIL reset_request: got %b expected 0000", req_vec); end
        checks++; if (job_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready: got %b expected 1111", job_ready); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (timeout !== 4'b0000) begin errors++; $display("FAIL reset_timeout: got %b expected 0000", timeout); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto: got %b expected 0", proto_err); end
        tick(1'b0, 4'h0, 4'h0, 4'h0);
        checks++; if (job_ready !== 4'b1111) begin errors++; $display("FAIL post_reset_ready: got %b expected 1111", job_ready); end
    endtask

    // Channel 1, len 3, grant two cycles after the offer, grant dropped in release
    task automatic test_single();
        logic [3:0] jv_t  [8];
        logic [3:0] g_t   [8];
        logic [3:0] req_t [8];
        logic [3:0] dn_t  [8];
        logic [3:0] rdy_t [8];
        int high;
        jv_t  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        g_t   = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        req_t = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        dn_t  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        rdy_t = '{4'he, 4'he, 4'he, 4'he, 4'he, 4'he, 4'hf, 4'hf};
        high = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, jv_t[k], 4'd3, g_t[k]);
            if (request1 === 1'b1) high++;
            checks++; if (req_vec !== req_t[k]) begin errors++; $display("FAIL single_request step %0d: got %b expected %b", k, req_vec, req_t[k]); end
            checks++; if (done !== dn_t[k]) begin errors++; $display("FAIL single_done step %0d: got %b expected %b", k, done, dn_t[k]); end
            checks++; if (job_ready !== rdy_t[k]) begin errors++; $display("FAIL single_ready step %0d: got %b expected %b", k, job_ready, rdy_t[k]); end
            checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto step %0d: got %b expected 0", k, proto_err); end
        end
        checks++; if (high != 5) begin errors++; $display("FAIL single_request_cycles: got %0d expected 5", high); end
    endtask

    // All four channels, len 0, granted one at a time in order
    task automatic test_all_channels();
        logic [3:0] exp_req;
        logic [3:0] exp_rdy;
        int pulses;
        tick(1'b0, 4'hf, 4'h0, 4'h0);
        checks++; if (req_vec !== 4'hf) begin errors++; $display("FAIL all_accept_request: got %b expected 1111", req_vec); end
        checks++; if (job_ready !== 4'h0) begin errors++; $display("FAIL all_accept_ready: got %b expected 0000", job_ready); end
        exp_req = 4'hf;
        exp_rdy = 4'h0;
        pulses  = 0;
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 4'h0, 4'h0, 4'(1 << c));
            checks++; if (req_vec !== exp_req) begin errors++; $display("FAIL all_hold_request ch%0d: got %b expected %b", c + 1, req_vec, exp_req); end
            checks++; if (done !== 4'h0) begin errors++; $display("FAIL all_hold_done ch%0d: got %b expected 0000", c + 1, done); end
            tick(1'b0, 4'h0, 4'h0, 4'(1 << c));
            exp_req = exp_req & ~4'(1 << c);
            checks++; if (req_vec !== exp_req) begin errors++; $display("FAIL all_rel_request ch%0d: got %b expected %b", c + 1, req_vec, exp_req); end
            tick(1'b0, 4'h0, 4'h0, 4'h0);
            exp_rdy = exp_rdy | 4'(1 << c);
            if (done !== 4'h0) pulses++;
            checks++; if (done !== 4'(1 << c)) begin errors++; $display("FAIL all_done ch%0d: got %b expected %b", c + 1, done, 4'(1 << c)); end
            checks++; if (job_ready !== exp_rdy) begin errors++; $display("FAIL all_ready ch%0d: got %b expected %b", c + 1, job_ready, exp_rdy); end
            checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL all_proto ch%0d: got %b expected 0", c + 1, proto_err); end
        end
        tick(1'b0, 4'h0, 4'h0, 4'h0);
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL all_done_clear: got %b expected 0000", done); end
        checks++; if (pulses != 4) begin errors++; $display("FAIL all_done_count: got %0d expected 4", pulses); end
    endtask

    // Multi-bit grant, then grant to an idle channel
    task automatic test_proto();
        logic [3:0] jv_t  [6];
        logic [3:0] g_t   [6];
        logic [3:0] req_t [6];
        logic       pe_t  [6];
        logic [3:0] rdy_t [6];
        jv_t  = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        g_t   = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h4, 4'h0};
        req_t = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
        pe_t  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rdy_t = '{4'hc, 4'hc, 4'hf, 4'hf, 4'hf, 4'hf};
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, jv_t[k], 4'd2, g_t[k]);
            checks++; if (proto_err !== pe_t[k]) begin errors++; $display("FAIL proto_pulse step %0d: got %b expected %b", k, proto_err, pe_t[k]); end
            checks++; if (req_vec !== req_t[k]) begin errors++; $display("FAIL proto_request step %0d: got %b expected %b", k, req_vec, req_t[k]); end
            checks++; if (job_ready !== rdy_t[k]) begin errors++; $display("FAIL proto_ready step %0d: got %b expected %b", k, job_ready, rdy_t[k]); end
            checks++; if (done !== 4'h0) begin errors++; $display("FAIL proto_done step %0d: got %b expected 0000", k, done); end
        end
    endtask

    // Channel 2, len 8, grant withdrawn after three hold cycles
    task automatic test_hold_drop();
        logic [3:0] jv_t  [6];
        logic [3:0] g_t   [6];
        logic [3:0] req_t [6];
        logic       pe_t  [6];
        jv_t  = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        g_t   = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        req_t = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        pe_t  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, jv_t[k], 4'd8, g_t[k]);
            checks++; if (req_vec !== req_t[k]) begin errors++; $display("FAIL drop_request step %0d: got %b expected %b", k, req_vec, req_t[k]); end
            checks++; if (proto_err !== pe_t[k]) begin errors++; $display("FAIL drop_proto step %0d: got %b expected %b", k, proto_err, pe_t[k]); end
            checks++; if (done !== 4'h0) begin errors++; $display("FAIL drop_done step %0d: got %b expected 0000", k, done); end
        end
        checks++; if (job_ready !== 4'hf) begin errors++; $display("FAIL drop_ready: got %b expected 1111", job_ready); end
    endtask

    // Reset in the middle of channel 1 holding the resource
    task automatic test_reset_hold();
        tick(1'b0, 4'h1, 4'd5, 4'h0);
        tick(1'b0, 4'h0, 4'd5, 4'h1);
        tick(1'b0, 4'h0, 4'd5, 4'h1);
        checks++; if (request1 !== 1'b1) begin errors++; $display("FAIL rsthold_pre_request: got %b expected 1", request1); end
        tick(1'b1, 4'h0, 4'd5, 4'h1);
        checks++; if (request1 !== 1'b0) begin errors++; $display("FAIL rsthold_request: got %b expected 0", request1); end
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL rsthold_done: got %b expected 0000", done); end
        checks++; if (job_ready !== 4'hf) begin errors++; $display("FAIL rsthold_ready: got %b expected 1111", job_ready); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rsthold_proto: got %b expected 0", proto_err); end
        tick(1'b0, 4'h0, 4'h0, 4'h0);
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL rsthold_after_done: got %b expected 0000", done); end
        checks++; if (req_vec !== 4'h0) begin errors++; $display("FAIL rsthold_after_request: got %b expected 0000", req_vec); end
    endtask

    // Random offers and lengths with a mostly well-behaved arbiter plus noise
    task automatic test_random();
        int         owner;
        int         c;
        int         r;
        logic       rst;
        logic [3:0] jv;
        logic [3:0] jl;
        logic [3:0] g;
        logic [3:0] cur;
        owner = -1;
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            jv  = 4'($urandom);
            jl  = 4'($urandom);
            if (owner >= 0) begin
                if (m_phase[owner] == P_IDLE) owner = -1;
                else if (m_phase[owner] == P_REL && $urandom_range(0, 1) == 1) owner = -1;
            end
            if (owner < 0 && $urandom_range(0, 1) == 1) begin
                c   = $urandom_range(0, 3);
                cur = m_req();
                if (cur[c] && m_phase[c] == P_WAIT) owner = c;
            end
            g = (owner >= 0) ? 4'(1 << owner) : 4'h0;
            r = $urandom_range(0, 59);
            if (r == 0) g = 4'($urandom);
            if (r == 1) begin
                owner = -1;
                g     = 4'h0;
            end
            if (rst) owner = -1;
            tick(rst, jv, jl, g);
            checks++; if (req_vec !== m_req()) begin errors++; $display("FAIL rand_request cycle %0d: got %b expected %b", n, req_vec, m_req()); end
            checks++; if (job_ready !== m_ready()) begin errors++; $display("FAIL rand_ready cycle %0d: got %b expected %b", n, job_ready, m_ready()); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done cycle %0d: got %b expected %b", n, done, m_done); end
            checks++; if (proto_err !== m_proto) begin errors++; $display("FAIL rand_proto cycle %0d: got %b expected %b", n, proto_err, m_proto); end
            checks++; if (timeout !== 4'h0) begin errors++; $display("FAIL rand_timeout cycle %0d: got %b expected 0000", n, timeout); end
        end
        tick(1'b1, 4'h0, 4'h0, 4'h0);
        tick(1'b0, 4'h0, 4'h0, 4'h0);
    endtask

    initial begin
        reset     = 1'b1;
        job_valid = 4'h0;
        job_len   = 4'h0;
        grant     = 4'h0;
        test_reset();
        test_single();
        test_all_channels();
        test_proto();
        test_hold_drop();
        test_reset_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
